// File: rtl/axi_sram_arbiter_pkg.sv
// axi_sram_arbiter_pkg: shared state, size type and ID constants for the AXI/SRAM arbiter
package axi_sram_arbiter_pkg;
   localparam int AXI_ID_W = 4;
   localparam logic [AXI_ID_W-1:0] INST_ID_DEF = 4'd0;
   localparam logic [AXI_ID_W-1:0] DATA_ID_DEF = 4'd1;
   typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} arb_state_t;
   typedef logic [2:0] axi_size_t;
   // SRAM size codes 0/1/2 map directly onto AXI byte/half/word sizes
   function automatic axi_size_t to_axi_size(input logic [1:0] s);
      return {1'b0, s};
   endfunction
endpackage

// File: rtl/axi_sram_arbiter_if.sv
// axi_sram_arbiter_if: both SRAM-like requester ports and the shared AXI3 master port
interface axi_sram_arbiter_if
   import axi_sram_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic                inst_req;
   logic [ADDR_W-1:0]   inst_addr;
   logic                inst_addr_ok;
   logic                inst_data_ok;
   logic [DATA_W-1:0]   inst_rdata;
   logic                data_req;
   logic                data_wr;
   logic [1:0]          data_size;
   logic [3:0]          data_wen;
   logic [ADDR_W-1:0]   data_addr;
   logic [DATA_W-1:0]   data_wdata;
   logic                data_addr_ok;
   logic                data_data_ok;
   logic [DATA_W-1:0]   data_rdata;
   logic [AXI_ID_W-1:0] arid;
   logic [ADDR_W-1:0]   araddr;
   logic [3:0]          arlen;
   axi_size_t           arsize;
   logic                arvalid;
   logic                arready;
   logic [AXI_ID_W-1:0] rid;
   logic [DATA_W-1:0]   rdata;
   logic                rlast;
   logic                rvalid;
   logic                rready;
   logic [AXI_ID_W-1:0] awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [3:0]          awlen;
   axi_size_t           awsize;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [3:0]          wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [AXI_ID_W-1:0] bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   // arbiter side: SRAM slave towards the core, AXI master towards memory
   modport master (
      input  inst_req, inst_addr, data_req, data_wr, data_size, data_wen, data_addr, data_wdata,
      output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
      output arid, araddr, arlen, arsize, arvalid, rready,
      input  arready, rid, rdata, rlast, rvalid,
      output awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
      input  awready, wready, bid, bresp, bvalid
   );

   // environment side: the core's requesters plus the AXI memory
   modport slave (
      output inst_req, inst_addr, data_req, data_wr, data_size, data_wen, data_addr, data_wdata,
      input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
      input  arid, araddr, arlen, arsize, arvalid, rready,
      output arready, rid, rdata, rlast, rvalid,
      input  awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
      output awready, wready, bid, bresp, bvalid
   );
endinterface

// File: rtl/axi_sram_arbiter_write_channel.sv
// axi_sram_arbiter_write_channel: independent AW/W completion tracking for a single-beat write
module axi_sram_arbiter_write_channel (
   input  logic clk,
   input  logic resetn,
   input  logic i_active,
   input  logic i_awready,
   input  logic i_wready,
   output logic o_awvalid,
   output logic o_wvalid,
   output logic o_done
);
   logic r_aw_done, r_w_done, w_aw_seen, w_w_seen;

   assign o_awvalid = i_active && !r_aw_done;
   assign o_wvalid  = i_active && !r_w_done;
   assign w_aw_seen = r_aw_done || (o_awvalid && i_awready);
   assign w_w_seen  = r_w_done || (o_wvalid && i_wready);
   assign o_done    = i_active && w_aw_seen && w_w_seen;

   // each channel remembers its own handshake; both clear once the write phase completes
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_aw_done <= i_active && !o_done && w_aw_seen;
         r_w_done  <= i_active && !o_done && w_w_seen;
      end
   end
endmodule

// File: rtl/axi_sram_arbiter.sv
// axi_sram_arbiter: shares one AXI3 master port between fetch and data SRAM-like requesters
module axi_sram_arbiter
   import axi_sram_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter logic [AXI_ID_W-1:0] INST_ID = INST_ID_DEF,
   parameter logic [AXI_ID_W-1:0] DATA_ID = DATA_ID_DEF
) (
   input logic clk,
   input logic resetn,
   axi_sram_arbiter_if.master bus
);
   arb_state_t          r_state;
   logic [AXI_ID_W-1:0] r_owner;
   logic                r_wr;
   logic [1:0]          r_size;
   logic [3:0]          r_wen;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_inst_data_ok, r_data_data_ok;
   logic [DATA_W-1:0]   r_inst_rdata, r_data_rdata;
   logic                w_idle, w_data_grant, w_inst_grant;
   logic                w_awvalid, w_wvalid, w_write_done, w_unused;

   // data side has fixed priority; grants are suppressed while reset is asserted
   assign w_idle       = resetn && r_state == IDLE;
   assign w_data_grant = w_idle && bus.data_req;
   assign w_inst_grant = w_idle && bus.inst_req && !bus.data_req;

   assign bus.data_addr_ok = w_data_grant;
   assign bus.inst_addr_ok = w_inst_grant;
   assign bus.inst_data_ok = r_inst_data_ok;
   assign bus.data_data_ok = r_data_data_ok;
   assign bus.inst_rdata   = r_inst_rdata;
   assign bus.data_rdata   = r_data_rdata;

   assign bus.arid    = r_owner;
   assign bus.araddr  = r_addr;
   assign bus.arlen   = 4'd0;
   assign bus.arsize  = to_axi_size(r_size);
   assign bus.arvalid = r_state == RADDR;
   assign bus.rready  = r_state == RDATA;
   assign bus.awid    = r_owner;
   assign bus.awaddr  = r_addr;
   assign bus.awlen   = 4'd0;
   assign bus.awsize  = to_axi_size(r_size);
   assign bus.awvalid = w_awvalid;
   assign bus.wdata   = r_wdata;
   assign bus.wstrb   = r_wen;
   assign bus.wlast   = 1'b1;
   assign bus.wvalid  = w_wvalid;
   assign bus.bready  = r_state == WRESP;

   // with a single outstanding transaction the response IDs, rlast and bresp carry no information
   assign w_unused = ^{bus.rid, bus.rlast, bus.bid, bus.bresp};

   axi_sram_arbiter_write_channel u_write_channel (
      .clk       (clk),
      .resetn    (resetn),
      .i_active  (r_state == WADDR),
      .i_awready (bus.awready),
      .i_wready  (bus.wready),
      .o_awvalid (w_awvalid),
      .o_wvalid  (w_wvalid),
      .o_done    (w_write_done)
   );

   // transaction FSM: capture the winner, walk the AXI handshakes, pulse data_ok on completion
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state        <= IDLE;
         r_owner        <= '0;
         r_wr           <= 1'b0;
         r_size         <= 2'd0;
         r_wen          <= 4'd0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_inst_data_ok <= 1'b0;
         r_data_data_ok <= 1'b0;
         r_inst_rdata   <= '0;
         r_data_rdata   <= '0;
      end else begin
         r_inst_data_ok <= 1'b0;
         r_data_data_ok <= 1'b0;
         case (r_state)
            IDLE: if (w_data_grant || w_inst_grant) begin
               r_owner <= w_data_grant ? DATA_ID : INST_ID;
               r_wr    <= w_data_grant && bus.data_wr;
               r_size  <= w_data_grant ? bus.data_size : 2'd2;
               r_wen   <= w_data_grant ? bus.data_wen : 4'd0;
               r_addr  <= w_data_grant ? bus.data_addr : bus.inst_addr;
               r_wdata <= w_data_grant ? bus.data_wdata : '0;
               r_state <= (w_data_grant && bus.data_wr) ? WADDR : RADDR;
            end
            RADDR: if (bus.arready) r_state <= RDATA;
            RDATA: if (bus.rvalid) begin
               if (r_owner == INST_ID) begin
                  r_inst_rdata   <= bus.rdata;
                  r_inst_data_ok <= 1'b1;
               end else begin
                  r_data_rdata   <= bus.rdata;
                  r_data_data_ok <= 1'b1;
               end
               r_state <= IDLE;
            end
            WADDR: if (w_write_done) r_state <= WRESP;
            WRESP: if (bus.bvalid) begin
               r_data_data_ok <= 1'b1;
               r_state        <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_sram_arbiter.sv
// tb_axi_sram_arbiter: directed stimulus, reactive AXI slave and a transaction-level reference model
module tb_axi_sram_arbiter;
   logic clk = 1'b0;
   logic resetn;
   int   checks = 0;
   int   failures = 0;

   axi_sram_arbiter_if bus ();

   axi_sram_arbiter dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // reactive slave: each ready/valid answers after the arbiter's signal has been up for *_dly cycles
   int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   logic [31:0] slave_rdata = 32'h0;
   logic [3:0]  last_arid, last_awid;
   logic [31:0] last_araddr, last_awaddr, last_wdata;
   logic [2:0]  last_arsize, last_awsize;
   logic [3:0]  last_wstrb;
   logic        last_wlast;

   always @(posedge clk) begin
      #1;
      if (!resetn) begin
         {bus.arready, bus.rvalid, bus.awready, bus.wready, bus.bvalid} = '0;
         {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
      end else begin
         if (bus.arvalid) begin bus.arready = ar_cnt >= ar_dly; ar_cnt++; end else begin bus.arready = 1'b0; ar_cnt = 0; end
         if (bus.rready) begin bus.rvalid = r_cnt >= r_dly; r_cnt++; end else begin bus.rvalid = 1'b0; r_cnt = 0; end
         if (bus.awvalid) begin bus.awready = aw_cnt >= aw_dly; aw_cnt++; end else begin bus.awready = 1'b0; aw_cnt = 0; end
         if (bus.wvalid) begin bus.wready = w_cnt >= w_dly; w_cnt++; end else begin bus.wready = 1'b0; w_cnt = 0; end
         if (bus.bready) begin bus.bvalid = b_cnt >= b_dly; b_cnt++; end else begin bus.bvalid = 1'b0; b_cnt = 0; end
      end
      bus.rdata = slave_rdata;
   end

   // remember what each completed handshake carried
   always @(negedge clk) begin
      if (bus.arvalid && bus.arready) begin last_arid = bus.arid; last_araddr = bus.araddr; last_arsize = bus.arsize; end
      if (bus.awvalid && bus.awready) begin last_awid = bus.awid; last_awaddr = bus.awaddr; last_awsize = bus.awsize; end
      if (bus.wvalid && bus.wready) begin last_wdata = bus.wdata; last_wstrb = bus.wstrb; last_wlast = bus.wlast; end
   end

   // reference model: one outstanding transaction tracked by which handshakes have completed
   logic        m_busy = 1'b0, m_wr = 1'b0, m_inst = 1'b0;
   logic        m_ar = 1'b0, m_aw = 1'b0, m_w = 1'b0;
   logic        m_ok_inst = 1'b0, m_ok_data = 1'b0;
   logic [3:0]  m_id = 4'd0, m_wen = 4'd0;
   logic [2:0]  m_size = 3'd0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
   logic        e_dok, e_iok, e_ar, e_r, e_aw, e_w, e_b;

   always @(negedge clk) begin
      if (!resetn) begin
         chk("reset_outputs", {55'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready,
             bus.inst_addr_ok, bus.data_addr_ok, bus.inst_data_ok, bus.data_data_ok}, 64'd0);
         {m_busy, m_ar, m_aw, m_w, m_ok_inst, m_ok_data} = '0;
      end else begin
         e_dok = !m_busy && bus.data_req;
         e_iok = !m_busy && bus.inst_req && !bus.data_req;
         e_ar  = m_busy && !m_wr && !m_ar;
         e_r   = m_busy && !m_wr && m_ar;
         e_aw  = m_busy && m_wr && !m_aw;
         e_w   = m_busy && m_wr && !m_w;
         e_b   = m_busy && m_wr && m_aw && m_w;
         chk("data_addr_ok", bus.data_addr_ok, e_dok);
         chk("inst_addr_ok", bus.inst_addr_ok, e_iok);
         chk("inst_data_ok", bus.inst_data_ok, m_ok_inst);
         chk("data_data_ok", bus.data_data_ok, m_ok_data);
         chk("valid_ready", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, {e_ar, e_r, e_aw, e_w, e_b});
         if (m_ok_inst) chk("inst_rdata", bus.inst_rdata, m_rdata);
         if (m_ok_data && !m_wr) chk("data_rdata", bus.data_rdata, m_rdata);
         if (e_ar) chk("ar_fields", {bus.arid, bus.araddr, bus.arsize, bus.arlen}, {m_id, m_addr, m_size, 4'd0});
         if (e_aw) chk("aw_fields", {bus.awid, bus.awaddr, bus.awsize, bus.awlen}, {m_id, m_addr, m_size, 4'd0});
         if (e_w) chk("w_fields", {bus.wdata, bus.wstrb, bus.wlast}, {m_wdata, m_wen, 1'b1});
         m_ok_inst = 1'b0;
         m_ok_data = 1'b0;
         if (m_busy) begin
            if (e_ar && bus.arready) m_ar = 1'b1;
            if (e_r && bus.rvalid) begin
               m_busy = 1'b0; m_rdata = bus.rdata;
               if (m_inst) m_ok_inst = 1'b1; else m_ok_data = 1'b1;
            end
            if (e_b && bus.bvalid) begin m_busy = 1'b0; m_ok_data = 1'b1; end
            if (e_aw && bus.awready) m_aw = 1'b1;
            if (e_w && bus.wready) m_w = 1'b1;
         end else if (e_dok || e_iok) begin
            m_busy = 1'b1; m_inst = e_iok; m_ar = 1'b0; m_aw = 1'b0; m_w = 1'b0;
            m_id   = e_dok ? 4'd1 : 4'd0;
            m_wr   = e_dok && bus.data_wr;
            m_size = e_dok ? {1'b0, bus.data_size} : 3'd2;
            m_addr = e_dok ? bus.data_addr : bus.inst_addr;
            m_wen  = bus.data_wen;
            m_wdata = bus.data_wdata;
         end
      end
   end

   task automatic req_inst(input logic [31:0] a);
      int n = 0;
      bus.inst_req = 1'b1; bus.inst_addr = a;
      do begin @(negedge clk); n++; end while (!bus.inst_addr_ok && n < 50);
      chk("inst_grant_timeout", bus.inst_addr_ok, 1'b1);
      @(posedge clk); #1;
      bus.inst_req = 1'b0;
   endtask

   task automatic req_data(input logic wr, input logic [1:0] sz, input logic [3:0] wen,
                           input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      bus.data_req = 1'b1; bus.data_wr = wr; bus.data_size = sz; bus.data_wen = wen;
      bus.data_addr = a; bus.data_wdata = d;
      do begin @(negedge clk); n++; end while (!bus.data_addr_ok && n < 50);
      chk("data_grant_timeout", bus.data_addr_ok, 1'b1);
      @(posedge clk); #1;
      bus.data_req = 1'b0;
   endtask

   task automatic wait_ok(input logic inst, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!(inst ? bus.inst_data_ok : bus.data_data_ok) && n < 100);
      chk(inst ? "inst_data_ok_timeout" : "data_data_ok_timeout", inst ? bus.inst_data_ok : bus.data_data_ok, 1'b1);
   endtask

   initial begin
      int n, oks, grants, last_ok;
      logic g;
      resetn = 1'b0;
      {bus.inst_req, bus.data_req, bus.data_wr} = '0;
      bus.inst_addr = '0; bus.data_addr = '0; bus.data_wdata = '0;
      bus.data_size = 2'd0; bus.data_wen = 4'd0;
      {bus.arready, bus.rvalid, bus.awready, bus.wready, bus.bvalid, bus.rlast} = '0;
      bus.rid = '0; bus.bid = '0; bus.bresp = '0; bus.rdata = '0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {bus.arvalid, bus.awvalid, bus.wvalid, bus.inst_data_ok, bus.data_data_ok}, 5'd0);
      @(posedge clk); #1;

      // fetch with a slow slave
      ar_dly = 2; r_dly = 3; slave_rdata = 32'h3C080001;
      req_inst(32'hBFC00000);
      wait_ok(1'b1, n);
      chk("t1_latency", n, 8);
      chk("t1_rdata", bus.inst_rdata, 32'h3C080001);
      chk("t1_ar", {last_arid, last_araddr, last_arsize}, {4'd0, 32'hBFC00000, 3'd2});
      @(negedge clk);
      chk("t1_pulse_width", bus.inst_data_ok, 1'b0);
      @(posedge clk); #1;

      // simultaneous requests: data wins, fetch is granted the cycle data_ok pulses
      ar_dly = 0; r_dly = 0; slave_rdata = 32'h11223344;
      bus.data_wr = 1'b0; bus.data_size = 2'd2; bus.data_addr = 32'h80001000; bus.data_req = 1'b1;
      bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC00004;
      @(negedge clk);
      chk("t2_priority", {bus.data_addr_ok, bus.inst_addr_ok}, 2'b10);
      @(posedge clk); #1;
      bus.data_req = 1'b0;
      wait_ok(1'b0, n);
      chk("t2_data_rdata", bus.data_rdata, 32'h11223344);
      chk("t2_data_ar", {last_arid, last_araddr}, {4'd1, 32'h80001000});
      chk("t2_inst_regrant", bus.inst_addr_ok, 1'b1);
      @(posedge clk); #1;
      bus.inst_req = 1'b0;
      wait_ok(1'b1, n);
      chk("t2_inst_ar", {last_arid, last_araddr}, {4'd0, 32'hBFC00004});
      @(posedge clk); #1;

      // byte write
      aw_dly = 1; w_dly = 1; b_dly = 2;
      req_data(1'b1, 2'd0, 4'b1000, 32'h80000003, 32'hAB000000);
      wait_ok(1'b0, n);
      chk("t3_aw", {last_awid, last_awaddr, last_awsize}, {4'd1, 32'h80000003, 3'd0});
      chk("t3_w", {last_wdata, last_wstrb, last_wlast}, {32'hAB000000, 4'b1000, 1'b1});
      @(posedge clk); #1;

      // W accepted three cycles before AW
      aw_dly = 3; w_dly = 0; b_dly = 0;
      req_data(1'b1, 2'd2, 4'b1111, 32'h80000010, 32'h12345678);
      @(negedge clk); chk("t4_c1", {bus.awvalid, bus.wvalid, bus.bready}, 3'b110);
      @(negedge clk); chk("t4_c2", {bus.awvalid, bus.wvalid, bus.bready}, 3'b100);
      @(negedge clk); chk("t4_c3", {bus.awvalid, bus.wvalid, bus.bready}, 3'b100);
      @(negedge clk); chk("t4_c4", {bus.awvalid, bus.wvalid, bus.bready, bus.awready}, 4'b1001);
      @(negedge clk); chk("t4_c5", {bus.awvalid, bus.wvalid, bus.bready}, 3'b001);
      @(negedge clk); chk("t4_c6", bus.data_data_ok, 1'b1);
      @(posedge clk); #1;

      // asynchronous reset while waiting for read data
      ar_dly = 0; r_dly = 20;
      req_inst(32'h00400000);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.rready && n < 50);
      chk("t5_reach_rdata", bus.rready, 1'b1);
      #2 resetn = 1'b0;
      #1 chk("t5_async_clear", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready,
                                bus.inst_addr_ok, bus.data_addr_ok, bus.inst_data_ok, bus.data_data_ok}, 9'd0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      r_dly = 0; slave_rdata = 32'hCAFEF00D;
      req_inst(32'h00400010);
      wait_ok(1'b1, n);
      chk("t5_after_reset", {bus.inst_rdata, last_araddr}, {32'hCAFEF00D, 32'h00400010});
      @(posedge clk); #1;

      // back-to-back fetches with an always-ready slave
      slave_rdata = 32'h24020007;
      bus.inst_req = 1'b1; bus.inst_addr = 32'h00001000;
      n = 0; oks = 0; grants = 0; last_ok = -1;
      while (oks < 4 && n < 100) begin
         @(negedge clk); n++;
         if (bus.inst_data_ok) begin
            if (last_ok >= 0) chk("t6_spacing", n - last_ok, 3);
            last_ok = n; oks++;
         end
         g = bus.inst_addr_ok;
         @(posedge clk); #1;
         if (g) begin
            grants++;
            if (grants == 4) bus.inst_req = 1'b0; else bus.inst_addr = bus.inst_addr + 32'd4;
         end
      end
      chk("t6_fetches", oks, 4);
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end
endmodule
